// File: rtl/mem_loader.sv
// Program loader: takes a length-prefixed byte stream, halts the CPU, and writes
// the payload into memory over the shared bus as address/data cycle pairs.
module mem_loader #(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter logic [15:0] TIMEOUT   = 16'd1000
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cpu_halted,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       halt_req,
  output logic       bus_drive,
  output logic [7:0] bus_out,
  output logic       mem_addr_we,
  output logic       mem_data_we,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] count
);

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    LEN,
    WAIT_BYTE,
    ADDR,
    DATA,
    DONE,
    ABORT
  } state_t;

  state_t      state, state_n;
  logic [7:0]  addr, addr_n;
  logic [7:0]  payload, payload_n;
  logic [7:0]  remaining, remaining_n;
  logic [15:0] timer, timer_n;
  logic        error_n;
  logic [7:0]  count_n;

  logic        xfer;
  logic        timeout_hit;

  // Every output is decoded from registered state only, so a reset edge
  // releases the bus and halt request immediately.
  assign busy      = (state != IDLE);
  assign halt_req  = busy;
  assign in_ready  = (state == LEN) || (state == WAIT_BYTE);
  assign xfer      = in_valid && in_ready;
  assign timeout_hit = (timer == (TIMEOUT - 16'd1));

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= BASE_ADDR;
      payload   <= '0;
      remaining <= '0;
      timer     <= '0;
      error     <= 1'b0;
      count     <= '0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      payload   <= payload_n;
      remaining <= remaining_n;
      timer     <= timer_n;
      error     <= error_n;
      count     <= count_n;
    end
  end

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    payload_n   = payload;
    remaining_n = remaining;
    timer_n     = '0;
    error_n     = error;
    count_n     = count;
    bus_drive   = 1'b0;
    bus_out     = '0;
    mem_addr_we = 1'b0;
    mem_data_we = 1'b0;
    done        = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = HALT_WAIT;
          error_n = 1'b0;
          count_n = '0;
          addr_n  = BASE_ADDR;
        end
      end

      HALT_WAIT: begin
        if (cpu_halted) state_n = LEN;
      end

      LEN: begin
        if (xfer) begin
          remaining_n = in_data;
          state_n     = (in_data == 8'h00) ? DONE : WAIT_BYTE;
        end else if (timeout_hit) begin
          state_n = ABORT;
        end else begin
          timer_n = timer + 16'd1;
        end
      end

      WAIT_BYTE: begin
        if (xfer) begin
          payload_n = in_data;
          state_n   = ADDR;
        end else if (timeout_hit) begin
          state_n = ABORT;
        end else begin
          timer_n = timer + 16'd1;
        end
      end

      ADDR: begin
        bus_drive   = 1'b1;
        bus_out     = addr;
        mem_addr_we = 1'b1;
        state_n     = DATA;
      end

      DATA: begin
        bus_drive   = 1'b1;
        bus_out     = payload;
        mem_data_we = 1'b1;
        addr_n      = addr + 8'd1;
        count_n     = count + 8'd1;
        remaining_n = remaining - 8'd1;
        state_n     = (remaining == 8'd1) ? DONE : WAIT_BYTE;
      end

      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end

      ABORT: begin
        error_n = 1'b1;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  a_we_exclusive: assert property (@(posedge clock) disable iff (!rst_n)
    !(mem_addr_we && mem_data_we));
  a_we_needs_bus: assert property (@(posedge clock) disable iff (!rst_n)
    (mem_addr_we || mem_data_we) |-> bus_drive);

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: two instances (base 00 / timeout 16, base FE)
// share stimulus; a negedge monitor collects the (address, data) bus writes.
module tb_mem_loader;

  logic       clock;
  logic       rst_n;
  logic       start;
  logic       cpu_halted;
  logic       in_valid;
  logic [7:0] in_data;

  logic       in_ready_a, halt_req_a, bus_drive_a, mem_addr_we_a, mem_data_we_a;
  logic       busy_a, done_a, error_a;
  logic [7:0] bus_out_a, count_a;
  logic       in_ready_b, halt_req_b, bus_drive_b, mem_addr_we_b, mem_data_we_b;
  logic       busy_b, done_b, error_b;
  logic [7:0] bus_out_b, count_b;

  int vectors;
  int miscompares;

  mem_loader #(.BASE_ADDR(8'h00), .TIMEOUT(16'd16)) dut_a (
    .clock(clock), .rst_n(rst_n), .start(start), .cpu_halted(cpu_halted),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .halt_req(halt_req_a), .bus_drive(bus_drive_a), .bus_out(bus_out_a),
    .mem_addr_we(mem_addr_we_a), .mem_data_we(mem_data_we_a), .busy(busy_a),
    .done(done_a), .error(error_a), .count(count_a)
  );

  mem_loader #(.BASE_ADDR(8'hFE), .TIMEOUT(16'd1000)) dut_b (
    .clock(clock), .rst_n(rst_n), .start(start), .cpu_halted(cpu_halted),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .halt_req(halt_req_b), .bus_drive(bus_drive_b), .bus_out(bus_out_b),
    .mem_addr_we(mem_addr_we_b), .mem_data_we(mem_data_we_b), .busy(busy_b),
    .done(done_b), .error(error_b), .count(count_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bus monitor: memory latches the address, then the data write pairs with it.
  logic [7:0]  lat_a, lat_b;
  logic [15:0] wr_a[$];
  logic [15:0] wr_b[$];
  int          done_cnt_a, addr_cnt_a, bad_a;

  always @(negedge clock) begin
    if (mem_addr_we_a) begin lat_a = bus_out_a; addr_cnt_a++; end
    if (mem_data_we_a) wr_a.push_back({lat_a, bus_out_a});
    if (done_a) done_cnt_a++;
    if ((mem_addr_we_a && mem_data_we_a) ||
        ((mem_addr_we_a || mem_data_we_a) && !bus_drive_a) ||
        (bus_drive_a && !halt_req_a)) bad_a++;
    if (mem_addr_we_b) lat_b = bus_out_b;
    if (mem_data_we_b) wr_b.push_back({lat_b, bus_out_b});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_a.delete();
    wr_b.delete();
    done_cnt_a = 0;
    addr_cnt_a = 0;
    bad_a      = 0;
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready_a && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy_a && cycles < 200) begin
      @(negedge clock);
      cycles++;
    end
    if (cycles >= 200) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    vectors = 0;
    miscompares = 0;
    clear_mon();
    lat_a = '0;
    lat_b = '0;

    // 1: reset with random inputs
    rst_n      = 1'b0;
    start      = 1'($urandom);
    cpu_halted = 1'($urandom);
    in_valid   = 1'($urandom);
    in_data    = 8'($urandom);
    @(posedge clock);
    #1;
    check("rst_in_ready", in_ready_a, 0);
    check("rst_halt_req", halt_req_a, 0);
    check("rst_bus_drive", bus_drive_a, 0);
    check("rst_bus_out", bus_out_a, 0);
    check("rst_addr_we", mem_addr_we_a, 0);
    check("rst_data_we", mem_data_we_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_error", error_a, 0);
    check("rst_count", count_a, 0);
    check("rst_busy_b", busy_b, 0);
    @(negedge clock);
    start = 1'b0; cpu_halted = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    clear_mon();

    // 2: basic load, halt acknowledged after 3 cycles
    pulse_start();
    check("b_halt_req", halt_req_a, 1);
    check("b_no_drive_pre_halt", bus_drive_a, 0);
    repeat (3) @(negedge clock);
    check("b_still_waiting", {busy_a, in_ready_a}, 2'b10);
    cpu_halted = 1'b1;
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    wait_idle(n);
    check("b_nwrites", wr_a.size(), 3);
    if (wr_a.size() == 3) begin
      check("b_wr0", wr_a[0], 16'h00AA);
      check("b_wr1", wr_a[1], 16'h01BB);
      check("b_wr2", wr_a[2], 16'h02CC);
    end
    check("b_done_pulses", done_cnt_a, 1);
    check("b_count", count_a, 3);
    check("b_halt_low", halt_req_a, 0);
    check("b_error", error_a, 0);
    check("b_bus_rules", bad_a, 0);
    clear_mon();

    // 3: zero-length stream
    pulse_start();
    send_byte(8'h00);
    wait_idle(n);
    check("z_nwrites", wr_a.size(), 0);
    check("z_addr_we", addr_cnt_a, 0);
    check("z_done_pulses", done_cnt_a, 1);
    check("z_count", count_a, 0);
    clear_mon();

    // 4: same stream, base 00 vs base FE (address wraps)
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    wait_idle(n);
    @(negedge clock);
    check("w_nwrites_b", wr_b.size(), 3);
    if (wr_b.size() == 3) begin
      check("w_wr0_b", wr_b[0], 16'hFE11);
      check("w_wr1_b", wr_b[1], 16'hFF22);
      check("w_wr2_b", wr_b[2], 16'h0033);
    end
    check("w_nwrites_a", wr_a.size(), 3);
    if (wr_a.size() == 3) check("w_wr2_a", wr_a[2], 16'h0233);
    check("w_count_b", count_b, 3);
    clear_mon();

    // 5: timeout after one payload byte (16-cycle stall)
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h55);
    wait_idle(n);
    check("t_cycles_to_idle", n, 19);
    check("t_error", error_a, 1);
    check("t_count", count_a, 1);
    check("t_bus_drive", bus_drive_a, 0);
    check("t_halt_req", halt_req_a, 0);
    check("t_done_pulses", done_cnt_a, 0);
    check("t_nwrites", wr_a.size(), 1);
    if (wr_a.size() == 1) check("t_wr0", wr_a[0], 16'h0055);
    pulse_start();
    check("t_error_cleared", error_a, 0);
    check("t_count_cleared", count_a, 0);

    // 6: extra start during ADDR is ignored; reset during DATA releases the bus
    send_byte(8'h01);
    send_byte(8'h77);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("r_in_data_state", {bus_drive_a, mem_data_we_a, bus_out_a}, {2'b11, 8'h77});
    rst_n = 1'b0;
    @(posedge clock);
    #1;
    check("r_bus_drive", bus_drive_a, 0);
    check("r_halt_req", halt_req_a, 0);
    check("r_busy", busy_a, 0);
    check("r_count", count_a, 0);
    @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
    check("r_stays_idle", busy_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit 500000");
    $fatal(1);
  end

endmodule
